// File: rtl/ovl_pkg.sv
// rtl/ovl_pkg.sv - shared types and sizes for the overlay RAM arbiter
package ovl_pkg;

    localparam int OVL_AW = 13;
    localparam int OVL_DW = 32;

    // Who drives the RAM in a given cycle; registered one cycle to tag the return.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_BUS_RD,
        OWN_BUS_WR
    } ram_owner_t;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/ovl_ram_arbiter_if.sv
// rtl/ovl_ram_arbiter_if.sv - bus, display and spram signal bundle for the overlay RAM arbiter
// Signals: bus_* (SPI decode side), disp_* (pixel shifter side), ram_* (spram side), ovf_clr.
// slave modport = arbiter view, master modport = surrounding logic view.
interface ovl_ram_arbiter_if #(
    parameter int AW = ovl_pkg::OVL_AW,
    parameter int DW = ovl_pkg::OVL_DW
) ();
    logic          bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ren;
    logic          bus_wen;
    logic [DW-1:0] bus_rdata;
    logic          bus_rvalid;
    logic          bus_busy;
    logic          bus_overflow;
    logic          ovf_clr;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  bus_sel, bus_addr, bus_wdata, bus_ren, bus_wen, ovf_clr,
        input  disp_req, disp_addr, ram_dout,
        output bus_rdata, bus_rvalid, bus_busy, bus_overflow,
        output disp_rdata, disp_rvalid, ram_addr, ram_we, ram_din
    );

    modport master (
        output bus_sel, bus_addr, bus_wdata, bus_ren, bus_wen, ovf_clr,
        output disp_req, disp_addr, ram_dout,
        input  bus_rdata, bus_rvalid, bus_busy, bus_overflow,
        input  disp_rdata, disp_rvalid, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/ovl_req_buf.sv
// rtl/ovl_req_buf.sv - one-entry pending buffer for bus requests with overflow detect
// In: clk, rst_n, bus_sel/ren/wen/addr/wdata, issue_en (no display request), ovf_clr.
// Out: full, pend_we/addr/wdata (entry contents), overflow (sticky drop flag).
module ovl_req_buf
    import ovl_pkg::*;
#(
    parameter int AW = OVL_AW,
    parameter int DW = OVL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_sel,
    input  logic          bus_ren,
    input  logic          bus_wen,
    input  logic [AW-1:0] bus_addr,
    input  logic [DW-1:0] bus_wdata,
    input  logic          issue_en,
    input  logic          ovf_clr,
    output logic          full,
    output logic          pend_we,
    output logic [AW-1:0] pend_addr,
    output logic [DW-1:0] pend_wdata,
    output logic          overflow
);
    buf_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          ovf_q, ovf_d;
    logic          accept, issue, load, drop;

    assign accept = bus_sel & (bus_ren | bus_wen);
    assign issue  = (state_q == BUF_FULL) & issue_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // The slot frees in an issue cycle, so a request landing then reloads it.
                if (issue) begin
                    if (accept) load = 1'b1;
                    else        state_d = BUF_EMPTY;
                end else if (accept) begin
                    drop = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        addr_d  = load ? bus_addr  : addr_q;
        wdata_d = load ? bus_wdata : wdata_q;
        // Simultaneous read and write strobes collapse to a write.
        we_d    = load ? bus_wen   : we_q;
        // Setting beats clearing in the same cycle.
        ovf_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        full       = (state_q == BUF_FULL);
        pend_we    = we_q;
        pend_addr  = addr_q;
        pend_wdata = wdata_q;
        overflow   = ovf_q;
    end
endmodule

// File: rtl/ovl_ram_arbiter.sv
// rtl/ovl_ram_arbiter.sv - shares the overlay spram between display fetch and the SPI bus
// In: clk_50mhz, rst_n, io.slave (bus requests, display requests, ram_dout).
// Out via io: bus/disp read returns, bus_busy, bus_overflow, ram_addr/we/din.
module ovl_ram_arbiter
    import ovl_pkg::*;
#(
    parameter int AW = OVL_AW,
    parameter int DW = OVL_DW
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    ovl_ram_arbiter_if.slave  io
);
    logic          pend_full, pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;
    ram_owner_t    owner, owner_q;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_c;
    logic [DW-1:0] bus_rdata_q, bus_rdata_d, disp_rdata_q, disp_rdata_d;
    logic          bus_rvalid_q, bus_rvalid_d, disp_rvalid_q, disp_rvalid_d;

    ovl_req_buf #(.AW(AW), .DW(DW)) u_req_buf (
        .clk        (clk_50mhz),
        .rst_n      (rst_n),
        .bus_sel    (io.bus_sel),
        .bus_ren    (io.bus_ren),
        .bus_wen    (io.bus_wen),
        .bus_addr   (io.bus_addr),
        .bus_wdata  (io.bus_wdata),
        .issue_en   (~io.disp_req),
        .ovf_clr    (io.ovf_clr),
        .full       (pend_full),
        .pend_we    (pend_we),
        .pend_addr  (pend_addr),
        .pend_wdata (pend_wdata),
        .overflow   (io.bus_overflow)
    );

    always_comb begin
        if (io.disp_req)    owner = OWN_DISP;
        else if (pend_full) owner = pend_we ? OWN_BUS_WR : OWN_BUS_RD;
        else                owner = OWN_NONE;
    end

    // With no owner the address is held to avoid needless toggling on the RAM pins.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_c   = 1'b0;
        case (owner)
            OWN_DISP:   ram_addr_d = io.disp_addr;
            OWN_BUS_RD: ram_addr_d = pend_addr;
            OWN_BUS_WR: begin
                ram_addr_d = pend_addr;
                ram_we_c   = 1'b1;
            end
            default:    ram_addr_d = ram_addr_q;
        endcase
        if (!rst_n) begin
            ram_addr_d = '0;
            ram_we_c   = 1'b0;
        end
    end

    // owner_q marks which requester the current ram_dout belongs to.
    always_comb begin
        bus_rvalid_d  = (owner_q == OWN_BUS_RD);
        disp_rvalid_d = (owner_q == OWN_DISP);
        bus_rdata_d   = bus_rvalid_d  ? io.ram_dout : bus_rdata_q;
        disp_rdata_d  = disp_rvalid_d ? io.ram_dout : disp_rdata_q;
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            owner_q       <= OWN_NONE;
            ram_addr_q    <= '0;
            bus_rdata_q   <= '0;
            bus_rvalid_q  <= 1'b0;
            disp_rdata_q  <= '0;
            disp_rvalid_q <= 1'b0;
        end else begin
            owner_q       <= owner;
            ram_addr_q    <= ram_addr_d;
            bus_rdata_q   <= bus_rdata_d;
            bus_rvalid_q  <= bus_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

    assign io.ram_addr    = ram_addr_d;
    assign io.ram_we      = ram_we_c;
    assign io.ram_din     = pend_wdata;
    assign io.bus_rdata   = bus_rdata_q;
    assign io.bus_rvalid  = bus_rvalid_q;
    assign io.bus_busy    = pend_full;
    assign io.disp_rdata  = disp_rdata_q;
    assign io.disp_rvalid = disp_rvalid_q;
endmodule
